// File: rtl/branch_predictor_gshare_if.sv
// Fetch-lookup and execute-resolution signal bundle of the gshare branch predictor.
// The master drives fetch PC and resolved branches; the slave is the predictor.
interface branch_predictor_gshare_if #(
  parameter int ADDR_W = 16,
  parameter int HIST_W = 3,
  parameter int RAS_PW = 2
);
  logic [ADDR_W-1:0] pc;
  logic              lookup_valid;
  logic [ADDR_W-1:0] npc_predict;
  logic              is_taken_predict;
  logic [HIST_W-1:0] pred_ghr;
  logic [RAS_PW-1:0] pred_ras_ptr;
  logic [RAS_PW:0]   pred_ras_cnt;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [1:0]        upd_type;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic [HIST_W-1:0] upd_ghr;
  logic [RAS_PW-1:0] upd_ras_ptr;
  logic [RAS_PW:0]   upd_ras_cnt;

  modport master (
    output pc, lookup_valid, upd_valid, upd_pc, upd_type, upd_taken, upd_target,
           upd_mispredict, upd_ghr, upd_ras_ptr, upd_ras_cnt,
    input  npc_predict, is_taken_predict, pred_ghr, pred_ras_ptr, pred_ras_cnt
  );

  modport slave (
    input  pc, lookup_valid, upd_valid, upd_pc, upd_type, upd_taken, upd_target,
           upd_mispredict, upd_ghr, upd_ras_ptr, upd_ras_cnt,
    output npc_predict, is_taken_predict, pred_ghr, pred_ras_ptr, pred_ras_cnt
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor: tagged typed BTB, 2-bit PHT indexed by pc^GHR, speculative RAS.
// Prediction is combinational; training and GHR/RAS checkpoint repair happen at posedge.
module branch_predictor_gshare #(
  parameter int ADDR_W    = 16,
  parameter int HIST_W    = 3,
  parameter int PHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_predictor_gshare_if.slave bus
);
  localparam int BTB_N  = 1 << BTB_IDX_W;
  localparam int PHT_N  = 1 << PHT_IDX_W;
  localparam int TAG_W  = ADDR_W - BTB_IDX_W - 2;
  localparam int RAS_PW = $clog2(RAS_DEPTH);
  localparam logic [RAS_PW:0]   RAS_FULL = (RAS_PW+1)'(RAS_DEPTH);
  localparam logic [RAS_PW:0]   CNT_ONE  = (RAS_PW+1)'(1);
  localparam logic [RAS_PW-1:0] PTR_ONE  = RAS_PW'(1);

  typedef enum logic [1:0] {T_COND = 2'd0, T_JUMP = 2'd1, T_CALL = 2'd2, T_RET = 2'd3} br_type_e;

  logic [BTB_N-1:0]     btb_valid_reg;
  logic [TAG_W-1:0]     btb_tag_reg    [BTB_N];
  logic [ADDR_W-1:0]    btb_target_reg [BTB_N];
  br_type_e             btb_type_reg   [BTB_N];
  logic [1:0]           pht_ctr        [PHT_N];
  logic [ADDR_W-1:0]    ras_reg        [RAS_DEPTH];
  logic [HIST_W-1:0]    ghr_reg, ghr_next;
  logic [RAS_PW-1:0]    ras_ptr_reg, ras_ptr_next;
  logic [RAS_PW:0]      ras_cnt_reg, ras_cnt_next;
  logic                 ras_we;
  logic [ADDR_W-1:0]    ras_wdata;

  logic [BTB_IDX_W-1:0] btb_idx, upd_btb_idx;
  logic [TAG_W-1:0]     tag;
  logic [PHT_IDX_W-1:0] pht_idx, upd_pht_idx;
  logic [ADDR_W-1:0]    pc_plus4, upd_pc_plus4, pred_target;
  logic                 hit, pred_taken, repair, btb_write;
  br_type_e             hit_type;

  assign btb_idx      = bus.pc[BTB_IDX_W+1:2];
  assign tag          = bus.pc[ADDR_W-1:BTB_IDX_W+2];
  assign pht_idx      = bus.pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_reg);
  assign upd_btb_idx  = bus.upd_pc[BTB_IDX_W+1:2];
  assign upd_pht_idx  = bus.upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(bus.upd_ghr);
  assign pc_plus4     = bus.pc + ADDR_W'(4);
  assign upd_pc_plus4 = bus.upd_pc + ADDR_W'(4);
  assign repair       = bus.upd_valid && bus.upd_mispredict;
  assign btb_write    = !rst && bus.upd_valid && bus.upd_taken;

  assign hit         = btb_valid_reg[btb_idx] && (btb_tag_reg[btb_idx] == tag);
  assign hit_type    = btb_type_reg[btb_idx];
  assign pred_taken  = !rst && hit && (hit_type != T_COND || pht_ctr[pht_idx][1]);
  assign pred_target = (hit_type == T_RET && ras_cnt_reg != '0) ? ras_reg[ras_ptr_reg]
                                                                 : btb_target_reg[btb_idx];

  assign bus.is_taken_predict = pred_taken;
  assign bus.npc_predict      = pred_taken ? pred_target : pc_plus4;
  assign bus.pred_ghr         = ghr_reg;
  assign bus.pred_ras_ptr     = ras_ptr_reg;
  assign bus.pred_ras_cnt     = ras_cnt_reg;

  // Repair restores the checkpoint and replays the resolved instruction; it overrides the lookup.
  always_comb begin
    ghr_next     = ghr_reg;
    ras_ptr_next = ras_ptr_reg;
    ras_cnt_next = ras_cnt_reg;
    ras_we       = 1'b0;
    ras_wdata    = pc_plus4;
    if (repair) begin
      ghr_next     = (bus.upd_type == T_COND) ? {bus.upd_ghr[HIST_W-2:0], bus.upd_taken}
                                              : bus.upd_ghr;
      ras_ptr_next = bus.upd_ras_ptr;
      ras_cnt_next = bus.upd_ras_cnt;
      ras_wdata    = upd_pc_plus4;
      if (bus.upd_type == T_CALL) begin
        ras_ptr_next = bus.upd_ras_ptr + PTR_ONE;
        ras_cnt_next = (bus.upd_ras_cnt < RAS_FULL) ? bus.upd_ras_cnt + CNT_ONE : RAS_FULL;
        ras_we       = 1'b1;
      end else if (bus.upd_type == T_RET && bus.upd_ras_cnt != '0) begin
        ras_ptr_next = bus.upd_ras_ptr - PTR_ONE;
        ras_cnt_next = bus.upd_ras_cnt - CNT_ONE;
      end
    end else if (bus.lookup_valid && hit) begin
      case (hit_type)
        T_COND: ghr_next = {ghr_reg[HIST_W-2:0], pred_taken};
        T_CALL: begin
          ras_ptr_next = ras_ptr_reg + PTR_ONE;
          ras_cnt_next = (ras_cnt_reg < RAS_FULL) ? ras_cnt_reg + CNT_ONE : RAS_FULL;
          ras_we       = 1'b1;
        end
        T_RET: begin
          if (ras_cnt_reg != '0) begin
            ras_ptr_next = ras_ptr_reg - PTR_ONE;
            ras_cnt_next = ras_cnt_reg - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_reg     <= '0;
      ras_ptr_reg <= '0;
      ras_cnt_reg <= '0;
    end else begin
      ghr_reg     <= ghr_next;
      ras_ptr_reg <= ras_ptr_next;
      ras_cnt_reg <= ras_cnt_next;
    end
  end

  // A push lands at the new top, so a full stack silently overwrites its oldest entry.
  always_ff @(posedge clk) begin
    if (!rst && ras_we) ras_reg[ras_ptr_next] <= ras_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) btb_valid_reg <= '0;
    else if (btb_write) btb_valid_reg[upd_btb_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (btb_write) begin
      btb_tag_reg[upd_btb_idx]    <= bus.upd_pc[ADDR_W-1:BTB_IDX_W+2];
      btb_target_reg[upd_btb_idx] <= bus.upd_target;
      btb_type_reg[upd_btb_idx]   <= br_type_e'(bus.upd_type);
    end
  end

  // Training indexes with the returned checkpoint, independent of the live GHR.
  genvar gi;
  generate
    for (gi = 0; gi < PHT_N; gi++) begin : g_pht
      logic [1:0] ctr_reg;
      logic       train;
      assign train = bus.upd_valid && (bus.upd_type == T_COND) && (upd_pht_idx == PHT_IDX_W'(gi));
      always_ff @(posedge clk) begin
        if (rst) begin
          ctr_reg <= 2'b01;
        end else if (train) begin
          if (bus.upd_taken) begin
            if (ctr_reg != 2'b11) ctr_reg <= ctr_reg + 2'b01;
          end else if (ctr_reg != 2'b00) begin
            ctr_reg <= ctr_reg - 2'b01;
          end
        end
      end
      assign pht_ctr[gi] = ctr_reg;
    end
  endgenerate
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench for branch_predictor_gshare: directed scenarios plus random traffic
// compared against an integer-arithmetic model of the predictor's rules.
module tb_branch_predictor_gshare;
  localparam int ADDR_W = 16, HIST_W = 3, PHT_IDX_W = 6, BTB_IDX_W = 4, RAS_DEPTH = 4, RAS_PW = 2;
  localparam int BTB_N = 16, PHT_N = 64, HIST_N = 8, ADDR_N = 65536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int pool [10] = '{32'h0040, 32'h0044, 32'h0440, 32'h0020, 32'h0210,
                    32'h0118, 32'h021C, 32'h0320, 32'h0424, 32'h0528};

  branch_predictor_gshare_if #(.ADDR_W(ADDR_W), .HIST_W(HIST_W), .RAS_PW(RAS_PW)) bus ();

  branch_predictor_gshare #(
    .ADDR_W(ADDR_W), .HIST_W(HIST_W), .PHT_IDX_W(PHT_IDX_W),
    .BTB_IDX_W(BTB_IDX_W), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference state: plain integers per table slot
  int m_valid [BTB_N];
  int m_tag   [BTB_N];
  int m_tgt   [BTB_N];
  int m_type  [BTB_N];
  int m_pht   [PHT_N];
  int m_ras   [RAS_DEPTH];
  int m_ghr, m_ptr, m_cnt;

  task automatic model_reset();
    for (int i = 0; i < BTB_N; i++) m_valid[i] = 0;
    for (int i = 0; i < PHT_N; i++) m_pht[i] = 1;
    m_ghr = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic ras_push(input int v);
    m_ptr = (m_ptr + 1) % RAS_DEPTH;
    m_ras[m_ptr] = v;
    if (m_cnt < RAS_DEPTH) m_cnt++;
  endtask

  task automatic ras_pop();
    m_ptr = (m_ptr + RAS_DEPTH - 1) % RAS_DEPTH;
    m_cnt--;
  endtask

  function automatic void lookup(input int p, output bit hit, output bit tk, output int np);
    int bi, ty;
    bi  = (p >> 2) % BTB_N;
    ty  = m_type[bi];
    hit = (m_valid[bi] != 0) && (m_tag[bi] == (p >> (BTB_IDX_W + 2)));
    tk  = !rst && hit && (ty != 0 || m_pht[((p >> 2) % PHT_N) ^ m_ghr] >= 2);
    np  = tk ? ((ty == 3 && m_cnt > 0) ? m_ras[m_ptr] : m_tgt[bi]) : (p + 4) % ADDR_N;
  endfunction

  function automatic logic [24:0] expect_out();
    bit h, t;
    int n;
    lookup(int'(bus.pc), h, t, n);
    return {t, 16'(n), 3'(m_ghr), 2'(m_ptr), 3'(m_cnt)};
  endfunction

  function automatic logic [24:0] observed();
    return {bus.is_taken_predict, bus.npc_predict, bus.pred_ghr, bus.pred_ras_ptr, bus.pred_ras_cnt};
  endfunction

  // Advance the model over the coming clock edge using the inputs currently driven
  task automatic model_step();
    bit hit, tk;
    int np, ty, up, ut, bi;
    if (rst) begin
      model_reset();
      return;
    end
    lookup(int'(bus.pc), hit, tk, np);
    ty = m_type[(int'(bus.pc) >> 2) % BTB_N];
    up = int'(bus.upd_pc);
    ut = int'(bus.upd_type);
    if (bus.upd_valid && bus.upd_mispredict) begin
      m_ghr = (ut == 0) ? (int'(bus.upd_ghr) * 2 + int'(bus.upd_taken)) % HIST_N : int'(bus.upd_ghr);
      m_ptr = int'(bus.upd_ras_ptr);
      m_cnt = int'(bus.upd_ras_cnt);
      if (ut == 2) ras_push((up + 4) % ADDR_N);
      else if (ut == 3 && m_cnt > 0) ras_pop();
    end else if (bus.lookup_valid && hit) begin
      if (ty == 0) m_ghr = (m_ghr * 2 + int'(tk)) % HIST_N;
      else if (ty == 2) ras_push((int'(bus.pc) + 4) % ADDR_N);
      else if (ty == 3 && m_cnt > 0) ras_pop();
    end
    if (bus.upd_valid) begin
      if (ut == 0) begin
        bi = ((up >> 2) % PHT_N) ^ int'(bus.upd_ghr);
        if (bus.upd_taken && m_pht[bi] < 3) m_pht[bi]++;
        else if (!bus.upd_taken && m_pht[bi] > 0) m_pht[bi]--;
      end
      if (bus.upd_taken) begin
        bi = (up >> 2) % BTB_N;
        m_valid[bi] = 1;
        m_tag[bi]   = up >> (BTB_IDX_W + 2);
        m_tgt[bi]   = int'(bus.upd_target);
        m_type[bi]  = ut;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.lookup_valid = 1'b0; bus.upd_valid = 1'b0; bus.upd_mispredict = 1'b0;
    bus.upd_pc = '0; bus.upd_type = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;
    bus.upd_ghr = '0; bus.upd_ras_ptr = '0; bus.upd_ras_cnt = '0;
  endtask

  task automatic train(input int p, input int ty, input bit taken, input int tgt, input int ghr);
    bus.lookup_valid = 1'b0;
    bus.upd_valid = 1'b1; bus.upd_mispredict = 1'b0;
    bus.upd_pc = 16'(p); bus.upd_type = 2'(ty); bus.upd_taken = taken;
    bus.upd_target = 16'(tgt); bus.upd_ghr = 3'(ghr);
    tick();
    bus.upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.pc = 16'h0040;
    tick();
    tick();
    vectors++;
    if (bus.is_taken_predict !== 1'b0 || bus.npc_predict !== 16'h0044) begin
      miscompares++;
      $display("FAIL reset_hold: got taken=%0b npc=%h want taken=0 npc=0044", bus.is_taken_predict, bus.npc_predict);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (observed() !== {1'b0, 16'h0044, 3'd0, 2'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", observed(), {1'b0, 16'h0044, 8'd0});
    end
  endtask

  task automatic test_cond();
    train(32'h0040, 0, 1'b1, 32'h0100, 0);
    train(32'h0040, 0, 1'b1, 32'h0100, 0);
    bus.pc = 16'h0040; #1;
    vectors++;
    if (bus.is_taken_predict !== 1'b1 || bus.npc_predict !== 16'h0100) begin
      miscompares++;
      $display("FAIL cond_taken: got taken=%0b npc=%h want taken=1 npc=0100", bus.is_taken_predict, bus.npc_predict);
    end
    train(32'h0040, 0, 1'b0, 32'h0100, 0);
    vectors++;
    if (observed() !== expect_out() || bus.is_taken_predict !== 1'b1) begin
      miscompares++;
      $display("FAIL cond_weak_taken: got %h want %h", observed(), expect_out());
    end
    train(32'h0040, 0, 1'b0, 32'h0100, 0);
    vectors++;
    if (bus.is_taken_predict !== 1'b0 || bus.npc_predict !== 16'h0044) begin
      miscompares++;
      $display("FAIL cond_weak_not_taken: got taken=%0b npc=%h want taken=0 npc=0044", bus.is_taken_predict, bus.npc_predict);
    end
    bus.pc = 16'h0440; #1;
    vectors++;
    if (bus.is_taken_predict !== 1'b0 || bus.npc_predict !== 16'h0444) begin
      miscompares++;
      $display("FAIL tag_miss: got taken=%0b npc=%h want taken=0 npc=0444", bus.is_taken_predict, bus.npc_predict);
    end
  endtask

  task automatic test_call_return();
    train(32'h0020, 2, 1'b1, 32'h0200, 0);
    train(32'h0210, 3, 1'b1, 32'h0300, 0);
    bus.pc = 16'h0020; bus.lookup_valid = 1'b1; #1;
    vectors++;
    if (observed() !== {1'b1, 16'h0200, 3'd0, 2'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL call_predict: got %h want %h", observed(), {1'b1, 16'h0200, 8'd0});
    end
    tick();
    bus.pc = 16'h0210; #1;
    vectors++;
    if (bus.npc_predict !== 16'h0024 || bus.pred_ras_cnt !== 3'd1) begin
      miscompares++;
      $display("FAIL return_from_ras: got npc=%h cnt=%0d want npc=0024 cnt=1", bus.npc_predict, bus.pred_ras_cnt);
    end
    tick();
    bus.lookup_valid = 1'b0; #1;
    vectors++;
    if (bus.npc_predict !== 16'h0300 || bus.pred_ras_cnt !== 3'd0 || bus.is_taken_predict !== 1'b1) begin
      miscompares++;
      $display("FAIL return_empty_ras: got npc=%h cnt=%0d want npc=0300 cnt=0", bus.npc_predict, bus.pred_ras_cnt);
    end
  endtask

  task automatic test_ras_overflow();
    int calls [5] = '{32'h0118, 32'h021C, 32'h0320, 32'h0424, 32'h0528};
    int rets [4]  = '{32'h052C, 32'h0428, 32'h0324, 32'h0220};
    for (int i = 0; i < 5; i++) train(calls[i], 2, 1'b1, 32'h0800 + i * 16, 0);
    for (int i = 0; i < 5; i++) begin
      bus.pc = 16'(calls[i]); bus.lookup_valid = 1'b1; #1;
      vectors++;
      if (observed() !== expect_out()) begin
        miscompares++;
        $display("FAIL call_push_%0d: got %h want %h", i, observed(), expect_out());
      end
      tick();
    end
    bus.lookup_valid = 1'b0; #1;
    vectors++;
    if (bus.pred_ras_cnt !== 3'd4) begin
      miscompares++;
      $display("FAIL ras_saturate: got cnt=%0d want cnt=4", bus.pred_ras_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      bus.pc = 16'h0210; bus.lookup_valid = 1'b1; #1;
      vectors++;
      if (bus.npc_predict !== 16'(rets[i])) begin
        miscompares++;
        $display("FAIL ras_pop_%0d: got npc=%h want npc=%h", i, bus.npc_predict, 16'(rets[i]));
      end
      tick();
    end
    bus.lookup_valid = 1'b0; #1;
    vectors++;
    if (bus.pred_ras_cnt !== 3'd0 || bus.npc_predict !== 16'h0300) begin
      miscompares++;
      $display("FAIL ras_drained: got npc=%h cnt=%0d want npc=0300 cnt=0", bus.npc_predict, bus.pred_ras_cnt);
    end
  endtask

  task automatic test_ghr_repair();
    idle();
    rst = 1'b1; tick(); rst = 1'b0;
    train(32'h0044, 0, 1'b1, 32'h0500, 0);
    train(32'h0044, 0, 1'b1, 32'h0500, 0);
    train(32'h0044, 0, 1'b1, 32'h0500, 1);
    train(32'h0044, 0, 1'b1, 32'h0500, 1);
    bus.pc = 16'h0044; bus.lookup_valid = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.pred_ghr !== 3'b011 || observed() !== expect_out()) begin
      miscompares++;
      $display("FAIL ghr_shift: got ghr=%b out=%h want ghr=011 out=%h", bus.pred_ghr, observed(), expect_out());
    end
    bus.upd_valid = 1'b1; bus.upd_mispredict = 1'b1; bus.upd_pc = 16'h0044;
    bus.upd_type = 2'd0; bus.upd_taken = 1'b0; bus.upd_ghr = 3'd0;
    bus.upd_ras_ptr = 2'(m_ptr); bus.upd_ras_cnt = 3'(m_cnt);
    tick();
    idle(); #1;
    vectors++;
    if (bus.pred_ghr !== 3'b000 || observed() !== expect_out()) begin
      miscompares++;
      $display("FAIL ghr_repair: got ghr=%b out=%h want ghr=000 out=%h", bus.pred_ghr, observed(), expect_out());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(7) == 0) bus.pc = 16'($urandom);
      else bus.pc = 16'(pool[$urandom_range(9)]);
      bus.lookup_valid   = 1'($urandom_range(1));
      bus.upd_valid      = ($urandom_range(2) == 0);
      bus.upd_pc         = 16'(pool[$urandom_range(9)]);
      bus.upd_type       = 2'($urandom_range(3));
      bus.upd_taken      = 1'($urandom_range(1));
      bus.upd_target     = 16'($urandom);
      bus.upd_mispredict = ($urandom_range(3) == 0);
      bus.upd_ghr        = 3'($urandom_range(7));
      bus.upd_ras_ptr    = 2'($urandom_range(3));
      bus.upd_ras_cnt    = 3'($urandom_range(4));
      #1;
      vectors++;
      if (observed() !== expect_out()) begin
        miscompares++;
        $display("FAIL random_%0d: pc=%h got %h want %h", i, bus.pc, observed(), expect_out());
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_mid_reset();
    train(32'h0020, 2, 1'b1, 32'h0200, 0);
    bus.pc = 16'h0020; bus.lookup_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 10; i++) begin
      bus.pc = 16'(pool[i]); #1;
      vectors++;
      if (observed() !== {1'b0, 16'(pool[i] + 4), 8'd0}) begin
        miscompares++;
        $display("FAIL mid_reset_miss_%0d: got %h want %h", i, observed(), {1'b0, 16'(pool[i] + 4), 8'd0});
      end
    end
    train(32'h0044, 0, 1'b1, 32'h0500, 0);
    bus.pc = 16'h0044; #1;
    vectors++;
    if (bus.is_taken_predict !== 1'b1 || bus.npc_predict !== 16'h0500 || observed() !== expect_out()) begin
      miscompares++;
      $display("FAIL mid_reset_ctr: got taken=%0b npc=%h want taken=1 npc=0500", bus.is_taken_predict, bus.npc_predict);
    end
  endtask

  initial begin
    bus.pc = '0;
    idle();
    test_reset();
    test_cond();
    test_call_return();
    test_ras_overflow();
    test_ghr_repair();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
